// File: rtl/lm_sm_seq.sv
// LM/SM multi-register transfer sequencer: one register per cycle, ascending index and address.
// N effective mask bits -> strobes in cycles 1..N, done in N+1; start is ignored while busy.
module lm_sm_seq #(
   parameter int DATA_W     = 16,
   parameter bit LM_SKIP_R7 = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_lm,
   input  logic [7:0]        reg_mask,
   input  logic [DATA_W-1:0] base_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [2:0]        rd_addr,
   output logic              reg_write,
   output logic [2:0]        wr_add,
   output logic [DATA_W-1:0] wr_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_pending;
   logic [DATA_W-1:0] r_addr_ptr;
   logic              r_is_lm;

   logic [7:0]        w_eff_mask;
   logic [2:0]        w_idx;
   logic              w_last;

   // R7 is the PC; the bank refuses LM writes to it, so the slot is dropped entirely.
   assign w_eff_mask = (is_lm && LM_SKIP_R7) ? {1'b0, reg_mask[6:0]} : reg_mask;

   always_comb begin
      w_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_idx = 3'(i);
         end
      end
   end

   assign w_last = ((r_pending & (r_pending - 8'd1)) == 8'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      mem_we      = 1'b0;
      reg_write   = 1'b0;
      mem_addr    = '0;
      rd_addr     = 3'd0;
      wr_add      = 3'd0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (w_eff_mask != 8'd0) ? S_XFER : S_DONE;
            end
         end
         S_XFER: begin
            busy     = 1'b1;
            mem_addr = r_addr_ptr;
            rd_addr  = w_idx;
            wr_add   = w_idx;
            if (r_is_lm) begin
               reg_write = 1'b1;
            end else begin
               mem_we = 1'b1;
            end
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // Reset kills strobes in the same cycle so an aborted slot never commits.
      if (rst) begin
         busy      = 1'b0;
         done      = 1'b0;
         mem_we    = 1'b0;
         reg_write = 1'b0;
         mem_addr  = '0;
         rd_addr   = 3'd0;
         wr_add    = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= 8'd0;
         r_addr_ptr <= '0;
         r_is_lm    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_lm    <= is_lm;
                  r_addr_ptr <= base_addr;
                  r_pending  <= w_eff_mask;
               end
            end
            S_XFER: begin
               r_pending  <= r_pending & ~(8'd1 << w_idx);
               r_addr_ptr <= r_addr_ptr + 1'b1;
            end
            default: begin
               r_pending <= r_pending;
            end
         endcase
      end
   end

   assign mem_wr_data = rd_data;
   assign wr_data     = mem_rd_data;

endmodule

// File: tb/tb_lm_sm_seq.sv
// Directed bench for lm_sm_seq with a behavioural memory and register bank.
module tb_lm_sm_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_lm;
   logic [7:0]  reg_mask;
   logic [15:0] base_addr;
   logic [15:0] mem_rd_data;
   logic [15:0] rd_data;
   logic        busy;
   logic        done;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wr_data;
   logic [2:0]  rd_addr;
   logic        reg_write;
   logic [2:0]  wr_add;
   logic [15:0] wr_data;

   logic [15:0] mem [0:65535];
   logic [15:0] regs [0:7];

   int n_tests = 0;
   int n_fail  = 0;

   assign mem_rd_data = mem[mem_addr];
   assign rd_data     = regs[rd_addr];

   always #5 clk = ~clk;

   lm_sm_seq #(.DATA_W(16), .LM_SKIP_R7(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .is_lm(is_lm), .reg_mask(reg_mask),
      .base_addr(base_addr), .mem_rd_data(mem_rd_data), .rd_data(rd_data),
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wr_data(mem_wr_data), .rd_addr(rd_addr), .reg_write(reg_write),
      .wr_add(wr_add), .wr_data(wr_data)
   );

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 16'(busy), 16'd0);
      chk({tag, "_done"}, 16'(done), 16'd0);
      chk({tag, "_we"},   16'(mem_we), 16'd0);
      chk({tag, "_rw"},   16'(reg_write), 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
      for (int r = 0; r < 8; r++) regs[r] = 16'h0000;
      rst = 1'b1; start = 1'b0; is_lm = 1'b0; reg_mask = 8'h00; base_addr = 16'h0000;
      step(); step();
      chk_idle("rst");
      chk("rst_maddr", mem_addr, 16'h0000);
      chk("rst_rdaddr", 16'(rd_addr), 16'd0);
      chk("rst_wradd", 16'(wr_add), 16'd0);
      rst = 1'b0;
      step();
      chk_idle("idle0");

      // LM mask 0x05 from 0x0010
      mem[16'h0010] = 16'hAAAA; mem[16'h0011] = 16'h5555;
      start = 1'b1; is_lm = 1'b1; reg_mask = 8'h05; base_addr = 16'h0010;
      step();
      start = 1'b0; reg_mask = 8'hFF; base_addr = 16'h7777; is_lm = 1'b0;
      chk("lm1_rw", 16'(reg_write), 16'd1);
      chk("lm1_we", 16'(mem_we), 16'd0);
      chk("lm1_wradd", 16'(wr_add), 16'd0);
      chk("lm1_wdata", wr_data, 16'hAAAA);
      chk("lm1_maddr", mem_addr, 16'h0010);
      chk("lm1_busy", 16'(busy), 16'd1);
      chk("lm1_done", 16'(done), 16'd0);
      step();
      chk("lm2_rw", 16'(reg_write), 16'd1);
      chk("lm2_wradd", 16'(wr_add), 16'd2);
      chk("lm2_wdata", wr_data, 16'h5555);
      chk("lm2_maddr", mem_addr, 16'h0011);
      step();
      chk("lm3_done", 16'(done), 16'd1);
      chk("lm3_busy", 16'(busy), 16'd1);
      chk("lm3_rw", 16'(reg_write), 16'd0);
      step();
      chk_idle("lm4");

      // SM mask 0x82 from 0x0100, R7 holds the PC
      regs[1] = 16'h1234; regs[7] = 16'h0042;
      start = 1'b1; is_lm = 1'b0; reg_mask = 8'h82; base_addr = 16'h0100;
      step();
      start = 1'b0;
      chk("sm1_we", 16'(mem_we), 16'd1);
      chk("sm1_rw", 16'(reg_write), 16'd0);
      chk("sm1_maddr", mem_addr, 16'h0100);
      chk("sm1_rdaddr", 16'(rd_addr), 16'd1);
      chk("sm1_wdata", mem_wr_data, 16'h1234);
      step();
      chk("sm2_we", 16'(mem_we), 16'd1);
      chk("sm2_maddr", mem_addr, 16'h0101);
      chk("sm2_rdaddr", 16'(rd_addr), 16'd7);
      chk("sm2_wdata", mem_wr_data, 16'h0042);
      step();
      chk("sm3_done", 16'(done), 16'd1);
      chk("sm3_we", 16'(mem_we), 16'd0);
      step();
      chk_idle("sm4");

      // LM with only R7 and with an empty mask: done in cycle 1, no strobes
      start = 1'b1; is_lm = 1'b1; reg_mask = 8'h80; base_addr = 16'h0200;
      step();
      start = 1'b0;
      chk("lm80_done", 16'(done), 16'd1);
      chk("lm80_rw", 16'(reg_write), 16'd0);
      chk("lm80_busy", 16'(busy), 16'd1);
      step();
      chk_idle("lm80_end");
      start = 1'b1; is_lm = 1'b1; reg_mask = 8'h00; base_addr = 16'h0300;
      step();
      start = 1'b0;
      chk("lm00_done", 16'(done), 16'd1);
      chk("lm00_rw", 16'(reg_write), 16'd0);
      step();
      chk_idle("lm00_end");

      // SM all registers across the address wrap, with a stray start in cycle 4
      for (int r = 0; r < 8; r++) regs[r] = 16'hA000 + 16'(r);
      start = 1'b1; is_lm = 1'b0; reg_mask = 8'hFF; base_addr = 16'hFFFE;
      for (int i = 0; i < 8; i++) begin
         logic [15:0] exp_addr;
         step();
         start = (i == 3) ? 1'b1 : 1'b0;
         is_lm = (i == 3) ? 1'b1 : 1'b0;
         reg_mask = 8'h01;
         exp_addr = 16'hFFFE + 16'(i);
         chk($sformatf("smff%0d_we", i + 1), 16'(mem_we), 16'd1);
         chk($sformatf("smff%0d_maddr", i + 1), mem_addr, exp_addr);
         chk($sformatf("smff%0d_rdaddr", i + 1), 16'(rd_addr), 16'(i));
         chk($sformatf("smff%0d_wdata", i + 1), mem_wr_data, 16'hA000 + 16'(i));
      end
      start = 1'b0;
      step();
      chk("smff9_done", 16'(done), 16'd1);
      chk("smff9_we", 16'(mem_we), 16'd0);
      step();
      chk_idle("smff10");
      step();
      chk_idle("smff11");

      // LM mask 0x0F aborted by reset in cycle 2
      mem[16'h0020] = 16'h1111; mem[16'h0021] = 16'h2222;
      start = 1'b1; is_lm = 1'b1; reg_mask = 8'h0F; base_addr = 16'h0020;
      step();
      start = 1'b0;
      chk("ab1_rw", 16'(reg_write), 16'd1);
      chk("ab1_wradd", 16'(wr_add), 16'd0);
      chk("ab1_wdata", wr_data, 16'h1111);
      step();
      rst = 1'b1;
      #1;
      chk("ab2_rw", 16'(reg_write), 16'd0);
      chk("ab2_busy", 16'(busy), 16'd0);
      step();
      rst = 1'b0;
      #1;
      chk_idle("ab3");
      step();
      chk_idle("ab4");

      // normal operation after the abort
      mem[16'h0030] = 16'hBEEF;
      start = 1'b1; is_lm = 1'b1; reg_mask = 8'h02; base_addr = 16'h0030;
      step();
      start = 1'b0;
      chk("re1_rw", 16'(reg_write), 16'd1);
      chk("re1_wradd", 16'(wr_add), 16'd1);
      chk("re1_wdata", wr_data, 16'hBEEF);
      chk("re1_maddr", mem_addr, 16'h0030);
      step();
      chk("re2_done", 16'(done), 16'd1);
      step();
      chk_idle("re3");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
